// File: rtl/minimig_host_arb_pkg.sv
// minimig_host_arb_pkg: shared state encoding and default timing constants for the host bus arbiter
package minimig_host_arb_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HALT_REQ,
    ST_XFER,
    ST_DONE,
    ST_WAIT_LOW,
    ST_HOLD
  } state_t;
  localparam int DEF_MAX_BURST = 8;
  localparam int DEF_LINGER = 16;
  localparam int DEF_CPU_GAP = 32;
  localparam int DEF_TIMEOUT = 255;
  localparam int IDLE_CYCLES = 2;
endpackage

// File: rtl/minimig_sat_counter.sv
// minimig_sat_counter: clear/load/increment/decrement counter that saturates at 0 and MAX
module minimig_sat_counter #(
  parameter int MAX = 1,
  parameter int W = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb
    cnt_d = clr_i ? '0 :
            ld_i  ? ld_val_i :
            inc_i ? (cnt_q == W'(MAX) ? cnt_q : cnt_q + W'(1)) :
            dec_i ? (cnt_q == '0 ? cnt_q : cnt_q - W'(1)) :
            cnt_q;
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/minimig_host_bus_arbiter.sv
// minimig_host_bus_arbiter: halts the 68k once its bus is idle and runs bounded host bursts
// through the bridge host port, with a forced CPU-only gap and a per-transfer timeout.
module minimig_host_bus_arbiter
  import minimig_host_arb_pkg::*;
#(
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int LINGER    = DEF_LINGER,
  parameter int CPU_GAP   = DEF_CPU_GAP,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clk7_en,
  input  logic        cpu_as_n,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [1:0]  host_bs,
  input  logic [22:0] host_adr,
  input  logic [15:0] host_wdat,
  output logic [15:0] host_rdat,
  output logic        host_done,
  output logic        host_err,
  output logic        busy,
  output logic        br_halt,
  output logic        br_cs,
  output logic        br_we,
  output logic [1:0]  br_bs,
  output logic [22:0] br_adr,
  output logic [15:0] br_wdat,
  input  logic [15:0] br_rdat,
  input  logic        br_ack
);
  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int GW = $clog2(CPU_GAP + 1);
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int LW = $clog2(LINGER + 1);
  state_t st_q, st_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [15:0] rdat_q, rdat_d;
  logic err_q, err_d;
  logic [GW-1:0] gap_cnt;
  logic [IW-1:0] idle_cnt;
  logic [TW-1:0] to_cnt;
  logic [LW-1:0] lin_cnt;
  logic start, rel, resume, tmo, xfer_end;
  // A grant may start on the cycle the gap counter reaches zero, so the CPU gets exactly CPU_GAP cycles
  always_comb begin
    start    = st_q == ST_IDLE && host_req && gap_cnt <= GW'(1);
    rel      = st_q == ST_HOLD && (burst_q == BW'(MAX_BURST) || lin_cnt == LW'(LINGER));
    resume   = st_q == ST_HOLD && !rel && host_req;
    tmo      = to_cnt == TW'(TIMEOUT - 1);
    xfer_end = st_q == ST_XFER && (br_ack || tmo);
    burst_d  = rel ? '0 :
               (st_q == ST_DONE && burst_q != BW'(MAX_BURST)) ? burst_q + BW'(1) : burst_q;
    err_d    = xfer_end ? !br_ack : err_q;
    rdat_d   = xfer_end ? (br_ack ? br_rdat : 16'h0000) : rdat_q;
    st_d     = st_q;
    case (st_q)
      ST_IDLE:     st_d = start ? ST_HALT_REQ : ST_IDLE;
      ST_HALT_REQ: st_d = !host_req ? ST_IDLE :
                          idle_cnt == IW'(IDLE_CYCLES) ? ST_XFER : ST_HALT_REQ;
      ST_XFER:     st_d = xfer_end ? ST_DONE : ST_XFER;
      ST_DONE:     st_d = ST_WAIT_LOW;
      ST_WAIT_LOW: st_d = host_req ? ST_WAIT_LOW : ST_HOLD;
      ST_HOLD:     st_d = rel ? ST_IDLE : resume ? ST_XFER : ST_HOLD;
      default:     st_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      st_q    <= ST_IDLE;
      burst_q <= '0;
      rdat_q  <= '0;
      err_q   <= 1'b0;
      br_we   <= 1'b0;
      br_bs   <= '0;
      br_adr  <= '0;
      br_wdat <= '0;
    end else if (clk7_en) begin
      st_q    <= st_d;
      burst_q <= burst_d;
      rdat_q  <= rdat_d;
      err_q   <= err_d;
      if (start || resume) begin
        br_we   <= host_we;
        br_bs   <= host_bs;
        br_adr  <= host_adr;
        br_wdat <= host_wdat;
      end
    end
  minimig_sat_counter #(.MAX(CPU_GAP)) u_gap (
    .clk(clk), .rst(rst), .en_i(clk7_en), .clr_i(1'b0), .ld_i(rel), .ld_val_i(GW'(CPU_GAP)),
    .inc_i(1'b0), .dec_i(st_q == ST_IDLE), .cnt_o(gap_cnt)
  );
  // The cycle that launches the halt request already counts as a CPU-idle sample
  minimig_sat_counter #(.MAX(IDLE_CYCLES)) u_idle (
    .clk(clk), .rst(rst), .en_i(clk7_en), .clr_i(st_q == ST_HALT_REQ && !cpu_as_n), .ld_i(start),
    .ld_val_i(IW'(cpu_as_n)), .inc_i(st_q == ST_HALT_REQ && cpu_as_n), .dec_i(1'b0), .cnt_o(idle_cnt)
  );
  minimig_sat_counter #(.MAX(TIMEOUT)) u_to (
    .clk(clk), .rst(rst), .en_i(clk7_en), .clr_i(st_q != ST_XFER), .ld_i(1'b0), .ld_val_i('0),
    .inc_i(st_q == ST_XFER), .dec_i(1'b0), .cnt_o(to_cnt)
  );
  minimig_sat_counter #(.MAX(LINGER)) u_lin (
    .clk(clk), .rst(rst), .en_i(clk7_en), .clr_i(st_q != ST_HOLD), .ld_i(1'b0), .ld_val_i('0),
    .inc_i(st_q == ST_HOLD && !rel && !host_req), .dec_i(1'b0), .cnt_o(lin_cnt)
  );
  assign busy      = st_q != ST_IDLE;
  assign br_halt   = busy;
  assign br_cs     = st_q == ST_XFER;
  assign host_done = st_q == ST_DONE;
  assign host_err  = host_done && err_q;
  assign host_rdat = rdat_q;
endmodule
